// File: rtl/rv_isa_pkg.sv
// Shared RV64 ISA constants and enums used by the encoder and the decode-side
// immediate stage.
package rv_isa_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_SD  = 3'b011;
    localparam logic [2:0] F3_BEQ = 3'b000;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        OPS_LD  = 2'b00,
        OPS_SD  = 2'b01,
        OPS_BEQ = 2'b10,
        OPS_INV = 2'b11
    } op_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/imm_pack.sv
// Combinational field packer: builds an ld/sd/beq word from decoded fields and
// flags immediates that cannot be represented (a NOP is substituted then).
module imm_pack
    import rv_isa_pkg::*;
(
    input  logic [1:0]  op_sel,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [63:0] imm,
    output logic [31:0] instr,
    output logic        err
);

    logic fits_i12;
    logic fits_b13;

    // Every bit above the field must replicate the field's sign bit.
    assign fits_i12 = (imm[63:11] == {53{imm[11]}});
    assign fits_b13 = (imm[63:12] == {52{imm[12]}}) && !imm[0];

    always_comb begin
        instr = NOP_WORD;
        err   = 1'b1;
        case (op_sel_e'(op_sel))
            OPS_LD: begin
                if (fits_i12) begin
                    instr = {imm[11:0], rs1, F3_LD, rd, OP_LOAD};
                    err   = 1'b0;
                end
            end
            OPS_SD: begin
                if (fits_i12) begin
                    instr = {imm[11:5], rs2, rs1, F3_SD, imm[4:0], OP_STORE};
                    err   = 1'b0;
                end
            end
            OPS_BEQ: begin
                if (fits_b13) begin
                    instr = {imm[12], imm[10:5], rs2, rs1, F3_BEQ,
                             imm[4:1], imm[11], OP_BRANCH};
                    err   = 1'b0;
                end
            end
            default: begin
                instr = NOP_WORD;
                err   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Burst encoder: accepts field bundles, packs them into instruction words and
// streams (address, word) writes toward instruction memory.
module instr_encoder
    import rv_isa_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op_sel,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [63:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_instr,
    output logic              out_err,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  err_count
);

    state_e             state_reg, state_next;
    logic [CNT_W-1:0]   num_reg;
    logic [CNT_W-1:0]   acc_reg;
    logic [CNT_W-1:0]   wr_reg;
    logic [CNT_W-1:0]   err_count_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [31:0]        instr_reg;
    logic               valid_reg;
    logic               err_reg;

    logic [31:0]        pack_instr;
    logic               pack_err;
    logic               accept;
    logic               out_hs;

    imm_pack u_imm_pack (
        .op_sel (op_sel),
        .rd     (rd),
        .rs1    (rs1),
        .rs2    (rs2),
        .imm    (imm),
        .instr  (pack_instr),
        .err    (pack_err)
    );

    assign in_ready = (state_reg == ST_RUN) && (acc_reg < num_reg)
                      && (!valid_reg || out_ready);
    assign accept   = in_valid && in_ready;
    assign out_hs   = valid_reg && out_ready;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start)
                    state_next = (num == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (out_hs && (wr_reg == num_reg - CNT_W'(1)))
                    state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            num_reg       <= '0;
            acc_reg       <= '0;
            wr_reg        <= '0;
            err_count_reg <= '0;
            addr_reg      <= '0;
            instr_reg     <= '0;
            valid_reg     <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && start) begin
                addr_reg      <= base_addr;
                num_reg       <= num;
                acc_reg       <= '0;
                wr_reg        <= '0;
                err_count_reg <= '0;
            end else begin
                // A new word may load in the same cycle the old one drains.
                if (accept) begin
                    valid_reg <= 1'b1;
                    instr_reg <= pack_instr;
                    err_reg   <= pack_err;
                    acc_reg   <= acc_reg + CNT_W'(1);
                    if (pack_err && (err_count_reg != '1))
                        err_count_reg <= err_count_reg + CNT_W'(1);
                end else if (out_hs) begin
                    valid_reg <= 1'b0;
                end
                if (out_hs) begin
                    addr_reg <= addr_reg + ADDR_W'(4);
                    wr_reg   <= wr_reg + CNT_W'(1);
                end
            end
        end
    end

    assign out_valid = valid_reg;
    assign out_addr  = addr_reg;
    assign out_instr = instr_reg;
    assign out_err   = err_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign done      = (state_reg == ST_DONE);
    assign err_count = err_count_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: bursts of hand-encoded vectors, backpressure,
// error substitution, zero-length burst and asynchronous reset mid-burst.
module tb_instr_encoder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] base_addr;
    logic [15:0] num;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op_sel;
    logic [4:0]  rd, rs1, rs2;
    logic [63:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_addr;
    logic [31:0] out_instr;
    logic        out_err;
    logic        busy;
    logic        done;
    logic [15:0] err_count;

    int checks_cnt = 0;
    int errors_cnt = 0;

    logic [1:0]  v_op   [8];
    logic [4:0]  v_rd   [8];
    logic [4:0]  v_rs1  [8];
    logic [4:0]  v_rs2  [8];
    logic [63:0] v_imm  [8];
    logic [31:0] v_exp  [8];
    logic        v_err  [8];

    instr_encoder #(.ADDR_W(64), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .num       (num),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sel    (op_sel),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_instr (out_instr),
        .out_err   (out_err),
        .busy      (busy),
        .done      (done),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [1:0] op, input logic [4:0] d,
                           input logic [4:0] s1, input logic [4:0] s2,
                           input logic [63:0] im, input logic [31:0] ex, input logic er);
        v_op[i] = op; v_rd[i] = d; v_rs1[i] = s1; v_rs2[i] = s2;
        v_imm[i] = im; v_exp[i] = ex; v_err[i] = er;
    endtask

    task automatic drive_in(input int i, input int n);
        if (i < n) begin
            in_valid = 1'b1;
            op_sel = v_op[i]; rd = v_rd[i]; rs1 = v_rs1[i]; rs2 = v_rs2[i]; imm = v_imm[i];
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic run_burst(input string name, input logic [63:0] base, input int n,
                             input int stall, input logic [15:0] exp_errs);
        int in_idx = 0;
        int out_idx = 0;
        int cyc = 0;
        int stall_left = stall;
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; num = 16'(n);
        @(posedge clk); #1;
        start = 1'b0;
        drive_in(in_idx, n);
        out_ready = 1'b1;
        while (out_idx < n && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check_eq({name, "_busy"}, 64'(busy), 64'd1);
                check_eq({name, "_first_latency"}, 64'(out_valid), 64'd0);
            end
            if (!out_ready) begin
                check_eq({name, "_hold_valid"}, 64'(out_valid), 64'd1);
                check_eq({name, "_hold_in_ready"}, 64'(in_ready), 64'd0);
                check_eq({name, "_hold_instr"}, 64'(out_instr), 64'(v_exp[out_idx]));
                check_eq({name, "_hold_addr"}, out_addr, base + 64'(4 * out_idx));
                stall_left--;
            end else if (out_valid) begin
                check_eq({name, "_addr"}, out_addr, base + 64'(4 * out_idx));
                check_eq({name, "_instr"}, 64'(out_instr), 64'(v_exp[out_idx]));
                check_eq({name, "_err"}, 64'(out_err), 64'(v_err[out_idx]));
                $display("%s word %0d addr=%h instr=%h err=%0d", name, out_idx, out_addr, out_instr, out_err);
                out_idx++;
            end
            if (in_valid && in_ready) in_idx++;
            @(posedge clk); #1;
            drive_in(in_idx, n);
            out_ready = !(out_idx >= 1 && stall_left > 0);
        end
        if (out_idx < n) check_eq({name, "_timeout_words"}, 64'(out_idx), 64'(n));
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq({name, "_done_pulse"}, 64'(done), 64'd1);
        check_eq({name, "_out_valid_at_done"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        check_eq({name, "_done_clear"}, 64'(done), 64'd0);
        check_eq({name, "_busy_clear"}, 64'(busy), 64'd0);
        check_eq({name, "_err_count"}, 64'(err_count), 64'(exp_errs));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; num = '0;
        in_valid = 1'b0; op_sel = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_out_addr", out_addr, 64'd0);
        check_eq("rst_out_instr", 64'(out_instr), 64'd0);
        check_eq("rst_err_count", 64'(err_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ld x5, 8(x2)
        set_vec(0, 2'b00, 5'd5, 5'd2, 5'd0, 64'd8, 32'h0081_3283, 1'b0);
        run_burst("ld", 64'h1000, 1, 0, 16'd0);

        // sd x5, 16(x2); beq x1, x2, -8
        set_vec(0, 2'b01, 5'd0, 5'd2, 5'd5, 64'd16, 32'h0051_3823, 1'b0);
        set_vec(1, 2'b10, 5'd0, 5'd1, 5'd2, -64'sd8, 32'hFE20_8CE3, 1'b0);
        run_burst("sd_beq", 64'h1000, 2, 0, 16'd0);

        set_vec(0, 2'b00, 5'd1, 5'd1, 5'd0, 64'd2048, 32'h0000_0013, 1'b1);
        set_vec(1, 2'b10, 5'd0, 5'd1, 5'd2, 64'd3, 32'h0000_0013, 1'b1);
        set_vec(2, 2'b11, 5'd3, 5'd4, 5'd5, 64'd0, 32'h0000_0013, 1'b1);
        run_burst("errs", 64'h1000, 3, 0, 16'd3);

        set_vec(0, 2'b00, 5'd1, 5'd0, 5'd0, 64'd0, 32'h0000_3083, 1'b0);
        set_vec(1, 2'b00, 5'd2, 5'd0, 5'd0, 64'd0, 32'h0000_3103, 1'b0);
        set_vec(2, 2'b00, 5'd3, 5'd0, 5'd0, 64'd0, 32'h0000_3183, 1'b0);
        set_vec(3, 2'b00, 5'd4, 5'd0, 5'd0, 64'd0, 32'h0000_3203, 1'b0);
        run_burst("bp", 64'h1000, 4, 3, 16'd0);

        // Range edges, plus upper-bit violation with clean low bits.
        set_vec(0, 2'b00, 5'd1, 5'd3, 5'd0, -64'sd2048, 32'h8001_B083, 1'b0);
        set_vec(1, 2'b01, 5'd0, 5'd6, 5'd4, 64'd2047, 32'h7E43_3FA3, 1'b0);
        set_vec(2, 2'b10, 5'd0, 5'd1, 5'd2, 64'd4094, 32'h7E20_8FE3, 1'b0);
        set_vec(3, 2'b10, 5'd0, 5'd1, 5'd2, -64'sd4096, 32'h8020_8063, 1'b0);
        set_vec(4, 2'b10, 5'd0, 5'd1, 5'd2, 64'd4096, 32'h0000_0013, 1'b1);
        set_vec(5, 2'b00, 5'd1, 5'd1, 5'd0, 64'h0000_0001_0000_0000, 32'h0000_0013, 1'b1);
        run_burst("edges", 64'hFFFF_FFFF_FFFF_FFF8, 6, 0, 16'd2);

        // Zero-length burst.
        @(posedge clk); #1;
        start = 1'b1; base_addr = 64'h3000; num = 16'd0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check_eq("zero_done", 64'(done), 64'd1);
        check_eq("zero_no_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check_eq("zero_done_clear", 64'(done), 64'd0);
        check_eq("zero_busy_clear", 64'(busy), 64'd0);
        check_eq("zero_no_valid2", 64'(out_valid), 64'd0);
        $display("zero burst checked");

        // Reset with a word pending.
        set_vec(0, 2'b00, 5'd5, 5'd2, 5'd0, 64'd8, 32'h0081_3283, 1'b0);
        @(posedge clk); #1;
        start = 1'b1; base_addr = 64'h1000; num = 16'd2;
        @(posedge clk); #1;
        start = 1'b0; out_ready = 1'b0;
        drive_in(0, 2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("mid_valid_before_rst", 64'(out_valid), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 64'(out_valid), 64'd0);
        check_eq("mid_rst_busy", 64'(busy), 64'd0);
        check_eq("mid_rst_done", 64'(done), 64'd0);
        check_eq("mid_rst_addr", out_addr, 64'd0);
        check_eq("mid_rst_instr", 64'(out_instr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        $display("reset mid-burst checked");
        run_burst("post_rst", 64'h2000, 1, 0, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Packs decoded instruction fields (operation select, register indices, 64-bit signed immediate) into 32-bit RV64 `ld`, `sd` and `beq` instruction words. Emits them as a sequential stream of (address, word) writes toward instruction memory. It is the encode-side counterpart of the sign-extend/immediate-extraction stage: words it emits must decode back to the same immediate. Used by the testbench loader and the boot-image builder to fill instruction memory before the core is released.

## Interface
Parameters:
- `ADDR_W`, 64: width of instruction addresses.
- `CNT_W`, 16: width of the instruction-count and error-count fields.

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: begin a burst; sampled only in IDLE.
- `base_addr`  in  ADDR_W: first write address, latched on `start`.
- `num`  in  CNT_W: number of instructions in the burst, latched on `start`.
- `in_valid`  in  1: field bundle valid.
- `in_ready`  out  1: encoder accepts the bundle this cycle.
- `op_sel`  in  2: operation select. 00 = ld, 01 = sd, 10 = beq, 11 = invalid.
- `rd`, `rs1`, `rs2`  in  5 each: register indices. Unused fields are ignored.
- `imm`  in  64: signed immediate. It is a byte offset for all three ops.
- `out_valid`  out  1: `out_addr`/`out_instr` valid.
- `out_ready`  in  1: memory side accepts the word.
- `out_addr`  out  ADDR_W: write address.
- `out_instr`  out  32: encoded word.
- `out_err`  out  1: the current output word is a substituted NOP.
- `busy`  out  1: state is not IDLE.
- `done`  out  1: one-cycle pulse when the burst completes.
- `err_count`  out  CNT_W: saturating count of erroneous bundles in the current burst.

## Operation
- FSM states and transitions:
  - IDLE: on `start`, latch `base_addr` and `num`, clear `err_count`, go to RUN. If `num`==0, go directly to DONE instead.
  - RUN: accept and emit bundles. When the last output handshake occurs (`num` words written), go to DONE.
  - DONE: assert `done` for one cycle, then return to IDLE.
- `in_ready` = (state==RUN) && (accepted < `num`) && (!`out_valid` || `out_ready`).
- Encoding of an accepted bundle:
  - ld: {imm[11:0], rs1, 3'b011, rd, 7'b0000011}.
  - sd: {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011}.
  - beq: {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011}.
- Range checks:
  - ld/sd: `imm` must lie in [-2048, 2047].
  - beq: `imm` must lie in [-4096, 4094] and `imm[0]` must be 0.
  - Check against all 64 bits: upper bits must equal the sign bit of the field.
- Errors: a range violation or `op_sel`==11 produces NOP 32'h00000013 with `out_err`=1. `err_count` increments by 1 and saturates at all-ones. The address still advances.
- `out_addr` = `base_addr` + 4×(number of words already written in the burst). It advances only on an output handshake and wraps modulo 2^ADDR_W.
- `start` is ignored in RUN and DONE. `in_valid` is ignored outside RUN.

## Timing
- Reset values: state IDLE; `in_ready`, `out_valid`, `out_err`, `busy` and `done` all 0; `out_addr`, `out_instr` and `err_count` all 0.
- Latency: input handshake at cycle N, so `out_valid`/`out_instr` registered at N+1.
- Throughput: one word per cycle while `out_ready` is held high.
- Output holding: while `out_valid` && !`out_ready`, `out_addr`, `out_instr` and `out_err` hold stable. A new bundle is accepted in the same cycle as an output handshake (pass-through, no bubble).
- `busy` is high from the cycle after `start` until the cycle after the `done` pulse.
- Asserting `rst_n` mid-burst drops any pending output immediately (`out_valid`=0) and returns to IDLE. No `done` pulse is produced.

## Structure
- Shared package `rv_isa_pkg`:
  - opcode constants OP_LOAD, OP_STORE, OP_BRANCH;
  - funct3 constants F3_LD, F3_SD, F3_BEQ;
  - NOP word;
  - `op_sel` enum;
  - FSM state enum.
  - The decode-side sign-extend stage uses the same opcode constants.
- One combinational sub-module `imm_pack`: inputs `op_sel`, fields and `imm`; outputs the 32-bit word and an error flag. The parent holds the FSM, counters and output register.

## Test plan
- ld: `start` with `base_addr`=0x1000, `num`=1; ld rd=5, rs1=2, imm=8 -> `out_addr`=0x1000, `out_instr`=0x00813283, `out_err`=0, then `done` pulse.
- sd then beq: `num`=2; sd rs2=5, rs1=2, imm=16, then beq rs1=1, rs2=2, imm=-8 -> 0x00513823 @0x1000, then 0xFE208CE3 @0x1004.
- Errors: `num`=3 with ld imm=2048, beq imm=3 and `op_sel`=11 -> three words of 0x00000013, each with `out_err`=1; `err_count`=3.
- Backpressure: `num`=4, `out_ready` low for 3 cycles after the first word -> outputs held stable, `in_ready`=0, no word lost or duplicated, addresses 0x1000–0x100C in order.
- Zero-length burst: `num`=0 -> `done` pulses 2 cycles after `start`, no `out_valid`.
- Reset mid-burst: `rst_n` low while `out_valid`=1 -> all outputs at reset values in the same cycle; after release, a new `start` with `base_addr`=0x2000 writes its first word at 0x2000.
